// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the 32-bit ALU and its share arbiter.
//               Holds the ALU op encodings, the legal-op helper and the lock
//               FSM state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [1:0] {
    ARB   = 2'b00,
    LOCK0 = 2'b01,
    LOCK1 = 2'b10
  } arb_state_e;

  function automatic logic is_legal_op(input logic [2:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_AND) ||
           (op == ALU_OR)  || (op == ALU_SLT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module      : alu
// Description : Combinational 32-bit ALU (add, sub, and, or, slt).
//               carry/zero/negative are driven to 1 when true and released to
//               high-impedance when false; the consumer supplies the pull.
// Ports       : a_i, b_i       - operands
//               alucontrol_i   - op select (alu_pkg encodings)
//               result_o       - result
//               overflow_o     - signed overflow (add/sub only)
//               carry_o        - carry out (add/sub only), 1 or Z
//               zero_o         - result is zero, 1 or Z
//               negative_o     - result MSB, 1 or Z
// Revision    : 1.0 - initial release
// ============================================================================
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       alucontrol_i,
  output logic [WIDTH-1:0] result_o,
  output logic             overflow_o,
  output wire              carry_o,
  output wire              zero_o,
  output wire              negative_o
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_diff;
  logic           w_slt;
  logic           w_carry;

  assign w_sum  = {1'b0, a_i} + {1'b0, b_i};
  // Carry of a + ~b + 1: 1 means no borrow.
  assign w_diff = {1'b0, a_i} + {1'b0, ~b_i} + {{WIDTH{1'b0}}, 1'b1};
  // Differing signs decide directly; otherwise the difference sign is exact.
  assign w_slt  = (a_i[WIDTH-1] ^ b_i[WIDTH-1]) ? a_i[WIDTH-1] : w_diff[WIDTH-1];

  always_comb begin
    result_o   = '0;
    overflow_o = 1'b0;
    w_carry    = 1'b0;
    case (alucontrol_i)
      ALU_ADD: begin
        result_o   = w_sum[WIDTH-1:0];
        w_carry    = w_sum[WIDTH];
        overflow_o = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (w_sum[WIDTH-1] != a_i[WIDTH-1]);
      end
      ALU_SUB: begin
        result_o   = w_diff[WIDTH-1:0];
        w_carry    = w_diff[WIDTH];
        overflow_o = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (w_diff[WIDTH-1] != a_i[WIDTH-1]);
      end
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_SLT: result_o = {{(WIDTH-1){1'b0}}, w_slt};
      default: result_o = '0;
    endcase
  end

  assign carry_o    = w_carry                 ? 1'b1 : 1'bz;
  assign zero_o     = (result_o == '0)        ? 1'b1 : 1'bz;
  assign negative_o = result_o[WIDTH-1]       ? 1'b1 : 1'bz;

endmodule
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arbiter
// Description : Shares one ALU between two requesters with round-robin
//               arbitration, a bounded grant lock and a single registered
//               valid/ready response stage tagged with the requester ID.
// Ports       : clk, rst_n                - clock, async active-low reset
//               reqN_valid/ready          - request handshake (N = 0, 1)
//               reqN_a, reqN_b, reqN_ctrl - operands and ALU op
//               reqN_lock                 - keep the grant for the next request
//               rsp_valid/ready           - response handshake
//               rsp_id, rsp_result        - requester ID and result
//               rsp_flags                 - {overflow, carry, zero, negative}
//               rsp_err                   - illegal op encoding
// Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int LOCK_MAX = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_ctrl,
  input  logic             req0_lock,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_ctrl,
  input  logic             req1_lock,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_flags,
  output logic             rsp_err
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  arb_state_e         state_q, state_d;
  logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic               last_grant_q, last_grant_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]   rsp_result_q, rsp_result_d;
  logic [3:0]         rsp_flags_q, rsp_flags_d;
  logic               rsp_err_q, rsp_err_d;

  logic               w_gnt;
  logic               w_gnt_valid;
  logic               w_stage_free;
  logic               w_accept;
  logic [WIDTH-1:0]   w_sel_a, w_sel_b, w_alu_result;
  logic [2:0]         w_sel_ctrl;
  logic               w_sel_lock;
  logic               w_alu_ov;
  // Undriven (Z) flag outputs of the ALU resolve to 0.
  tri0                w_alu_carry;
  tri0                w_alu_zero;
  tri0                w_alu_neg;

  // Grant selection: a lock pins the grant even when its owner is idle.
  always_comb begin
    w_gnt       = 1'b0;
    w_gnt_valid = 1'b0;
    case (state_q)
      LOCK0: w_gnt_valid = req0_valid;
      LOCK1: begin
        w_gnt       = 1'b1;
        w_gnt_valid = req1_valid;
      end
      default: begin
        w_gnt       = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
        w_gnt_valid = req0_valid | req1_valid;
      end
    endcase
  end

  assign w_stage_free = !rsp_valid_q || rsp_ready;
  // rst_n gate keeps both readys low while reset is held.
  assign w_accept     = rst_n && w_gnt_valid && w_stage_free;
  assign req0_ready   = w_accept && !w_gnt;
  assign req1_ready   = w_accept &&  w_gnt;

  assign w_sel_a    = w_gnt ? req1_a    : req0_a;
  assign w_sel_b    = w_gnt ? req1_b    : req0_b;
  assign w_sel_ctrl = w_gnt ? req1_ctrl : req0_ctrl;
  assign w_sel_lock = w_gnt ? req1_lock : req0_lock;

  alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .a_i          (w_sel_a),
    .b_i          (w_sel_b),
    .alucontrol_i (w_sel_ctrl),
    .result_o     (w_alu_result),
    .overflow_o   (w_alu_ov),
    .carry_o      (w_alu_carry),
    .zero_o       (w_alu_zero),
    .negative_o   (w_alu_neg)
  );

  always_comb begin
    state_d      = state_q;
    lock_cnt_d   = lock_cnt_q;
    last_grant_d = last_grant_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    rsp_err_d    = rsp_err_q;
    if (w_accept) begin
      // A new accept overwrites the stage even while it drains: no bubble.
      rsp_valid_d  = 1'b1;
      rsp_id_d     = w_gnt;
      last_grant_d = w_gnt;
      if (is_legal_op(w_sel_ctrl)) begin
        rsp_result_d = w_alu_result;
        rsp_flags_d  = {w_alu_ov, w_alu_carry, w_alu_zero, w_alu_neg};
        rsp_err_d    = 1'b0;
      end else begin
        rsp_result_d = '0;
        rsp_flags_d  = 4'b0010;
        rsp_err_d    = 1'b1;
      end
      if (state_q == ARB) begin
        // With LOCK_MAX of 1 the first grant already exhausts the lock.
        if (w_sel_lock && (LOCK_MAX > 1)) begin
          state_d    = w_gnt ? LOCK1 : LOCK0;
          lock_cnt_d = CNT_W'(1);
        end
      end else if (!w_sel_lock || ((lock_cnt_q + CNT_W'(1)) >= CNT_W'(LOCK_MAX))) begin
        state_d    = ARB;
        lock_cnt_d = '0;
      end else begin
        lock_cnt_d = lock_cnt_q + CNT_W'(1);
      end
    end else begin
      if (rsp_ready) begin
        rsp_valid_d = 1'b0;
      end
      // No accept while locked with a free stage means the owner went idle.
      if ((state_q != ARB) && w_stage_free) begin
        state_d    = ARB;
        lock_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB;
      lock_cnt_q   <= '0;
      last_grant_q <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      lock_cnt_q   <= lock_cnt_d;
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign rsp_err    = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_share_arbiter
// Description : Self-checking bench for alu_share_arbiter. Directed scenarios
//               followed by random traffic, all compared cycle by cycle with a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_share_arbiter;

  localparam int LOCK_MAX = 4;
  localparam int NONE     = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_lock;
  logic        req1_valid, req1_ready, req1_lock;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_ctrl, req1_ctrl;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic        m_valid, m_id, m_err, m_last;
  logic [31:0] m_result;
  logic [3:0]  m_flags;
  int          m_lock;   // -1 = arbitrating, else owner of the lock
  int          m_cnt;
  int          acc_id;   // requester the DUT accepted in the last step
  logic [31:0] snap;

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(32), .LOCK_MAX(LOCK_MAX)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ctrl  (req0_ctrl),
    .req0_lock  (req0_lock),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ctrl  (req1_ctrl),
    .req1_lock  (req1_lock),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .rsp_err    (rsp_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns {err, overflow, carry, zero, negative, result}, from plain arithmetic.
  function automatic logic [36:0] alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, sr;
    logic [31:0] r;
    logic ov, cy;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ov = 1'b0;
    cy = 1'b0;
    sr = 0;
    case (op)
      3'd0: begin sr = sa + sb; r = a + b; cy = (64'(a) + 64'(b)) > 64'hFFFF_FFFF; end
      3'd1: begin sr = sa - sb; r = a - b; cy = (a >= b); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd5: r = (sa < sb) ? 32'd1 : 32'd0;
      default: return {1'b1, 4'b0010, 32'd0};
    endcase
    if (op == 3'd0 || op == 3'd1) ov = (sr != longint'($signed(r)));
    return {1'b0, ov, cy, (r == 32'd0), r[31], r};
  endfunction

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 4))
      0: return 32'd0;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_id = 1'b0; m_err = 1'b0; m_last = 1'b1;
    m_result = 32'd0; m_flags = 4'd0; m_lock = -1; m_cnt = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_r0"}, req0_ready, 0);
    chk({tag, "_r1"}, req1_ready, 0);
    chk({tag, "_valid"}, rsp_valid, 0);
    chk({tag, "_id"}, rsp_id, 0);
    chk({tag, "_result"}, rsp_result, 0);
    chk({tag, "_flags"}, rsp_flags, 0);
    chk({tag, "_err"}, rsp_err, 0);
  endtask

  // One clock: compare DUT with model, advance the model, cross the edge.
  task automatic tick();
    logic free, g, gv, lk;
    logic [36:0] res;
    #1;
    free = !m_valid || rsp_ready;
    if (m_lock >= 0) begin
      g  = (m_lock == 1);
      gv = g ? req1_valid : req0_valid;
    end else begin
      g  = (req0_valid && req1_valid) ? !m_last : req1_valid;
      gv = req0_valid || req1_valid;
    end
    chk("ready0", req0_ready, free && gv && !g);
    chk("ready1", req1_ready, free && gv && g);
    chk("rsp_valid", rsp_valid, m_valid);
    if (m_valid) begin
      chk("rsp_id", rsp_id, m_id);
      chk("rsp_result", rsp_result, m_result);
      chk("rsp_flags", rsp_flags, m_flags);
      chk("rsp_err", rsp_err, m_err);
    end
    acc_id = req1_ready ? 1 : (req0_ready ? 0 : NONE);
    if (free && gv) begin
      res = g ? alu_ref(req1_ctrl, req1_a, req1_b) : alu_ref(req0_ctrl, req0_a, req0_b);
      lk  = g ? req1_lock : req0_lock;
      m_valid = 1'b1; m_id = g; m_err = res[36]; m_flags = res[35:32]; m_result = res[31:0];
      m_last = g;
      if (m_lock < 0) begin
        if (lk && LOCK_MAX > 1) begin m_lock = g ? 1 : 0; m_cnt = 1; end
      end else if (!lk || m_cnt + 1 >= LOCK_MAX) begin
        m_lock = -1; m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end else begin
      if (rsp_ready) m_valid = 1'b0;
      if (m_lock >= 0 && free) begin m_lock = -1; m_cnt = 0; end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1; req0_lock = 1'b0; req1_lock = 1'b0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0; req0_ctrl = 0; req1_ctrl = 0;
    rsp_ready = 1'b1;
    acc_id = NONE;
    model_reset();
    #3;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();

    // Add then sub on requester 0
    req0_valid = 1'b1; req0_ctrl = 3'b000; req0_a = 7; req0_b = 5;
    tick();
    chk("add_result", rsp_result, 12);
    chk("add_flags", rsp_flags, 4'b0000);
    chk("add_id", rsp_id, 0);
    req0_ctrl = 3'b001; req0_a = 5; req0_b = 7;
    tick();
    chk("sub_result", rsp_result, 32'hFFFF_FFFE);
    chk("sub_flags", rsp_flags, 4'b0001);

    // Tie: last grant was requester 0, so requester 1 leads
    req0_ctrl = 3'b010; req0_a = 32'hF0F0; req0_b = 32'hFF00;
    req1_valid = 1'b1; req1_ctrl = 3'b101; req1_a = 32'hFFFF_FFFF; req1_b = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("tie_grant", acc_id, (i % 2 == 0) ? 1 : 0);
      chk("tie_result", rsp_result, (i % 2 == 0) ? 32'd1 : 32'hF000);
    end

    // Lock: requester 1 holds the grant for at most LOCK_MAX accepts
    req0_valid = 1'b0; req1_lock = 1'b1; req1_ctrl = 3'b000;
    for (int i = 0; i < 6; i++) begin
      req1_a = $urandom; req1_b = $urandom;
      tick();
      chk("lock_grant", acc_id, (i == 4) ? 0 : 1);
      req0_valid = 1'b1;
    end
    // Owner idles while locked: the other requester still waits one cycle
    req1_valid = 1'b0; req1_lock = 1'b0;
    tick();
    chk("lock_idle", acc_id, NONE);
    tick();
    chk("lock_release", acc_id, 0);

    // Backpressure with both requesters valid
    req1_valid = 1'b1;
    rsp_ready = 1'b0;
    snap = rsp_result;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_noacc", acc_id, NONE);
      chk("bp_stable", rsp_result, snap);
    end
    rsp_ready = 1'b1;
    tick();

    // Illegal op, then signed overflow
    req1_valid = 1'b0;
    req0_ctrl = 3'b110; req0_a = 32'h1234; req0_b = 32'h5678;
    tick();
    chk("ill_err", rsp_err, 1);
    chk("ill_result", rsp_result, 0);
    chk("ill_flags", rsp_flags, 4'b0010);
    req0_ctrl = 3'b000; req0_a = 32'h7FFF_FFFF; req0_b = 1;
    tick();
    chk("ovf_result", rsp_result, 32'h8000_0000);
    chk("ovf_flags", rsp_flags, 4'b1001);
    chk("ovf_err", rsp_err, 0);

    // Reset while a response is pending
    req1_valid = 1'b1;
    chk("pre_rst_valid", rsp_valid, 1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_tie", acc_id, 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      req0_valid = ($urandom_range(0, 3) != 0);
      req1_valid = ($urandom_range(0, 3) != 0);
      req0_lock  = ($urandom_range(0, 2) == 0);
      req1_lock  = ($urandom_range(0, 2) == 0);
      req0_ctrl  = 3'($urandom_range(0, 7));
      req1_ctrl  = 3'($urandom_range(0, 7));
      req0_a = rnd_opnd(); req0_b = rnd_opnd();
      req1_a = rnd_opnd(); req1_b = rnd_opnd();
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
